// File: rtl/geet_fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : geet_fifo_rd_if / geet_stream_if
//  Description : Interfaces used by geet_fifo_stream_reader.
//                geet_fifo_rd_if - read port of a registered-output FIFO
//                  fifo_empty  FIFO empty flag (registered inside the FIFO)
//                  fifo_rd_en  pop request from the reader
//                  fifo_d_out  read data, valid one cycle after fifo_rd_en
//                geet_stream_if  - valid/ready stream towards downstream
//                  m_valid     data valid
//                  m_ready     downstream accepts m_data this cycle
//                  m_data      stream data
//                  buf_count   words currently held by the producer (0..2)
//                Modport "master" is the reader side in both interfaces.
//  Revision    : 1.0 - initial release
// ============================================================================

interface geet_fifo_rd_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_d_out;

    // Reader side: issues pops, consumes flag and data.
    modport master (
        input  fifo_empty,
        input  fifo_d_out,
        output fifo_rd_en
    );

    // FIFO side: supplies flag and data, receives pops.
    modport slave (
        output fifo_empty,
        output fifo_d_out,
        input  fifo_rd_en
    );
endinterface

interface geet_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [1:0]            buf_count;

    // Stream producer.
    modport master (
        output m_valid,
        output m_data,
        output buf_count,
        input  m_ready
    );

    // Stream consumer.
    modport slave (
        input  m_valid,
        input  m_data,
        input  buf_count,
        output m_ready
    );
endinterface

`default_nettype wire

// File: rtl/geet_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : geet_fifo_stream_reader
//  Description : Read-side adapter for registered-output FIFOs. Pops the FIFO
//                only when it is non-empty and a buffer slot is guaranteed,
//                absorbs the one-cycle read latency in a 2-entry skid buffer
//                and presents the words as a full-throughput valid/ready
//                stream.
//  Ports       : clk      - single clock, all logic on posedge
//                reset_n  - asynchronous active-low reset
//                flush    - synchronous discard of buffered/in-flight words
//                fifo     - geet_fifo_rd_if.master (FIFO read port)
//                strm     - geet_stream_if.master  (stream output + buf_count)
//  Revision    : 1.0 - initial release
// ============================================================================

module geet_fifo_stream_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  wire            clk,
    input  wire            reset_n,
    input  wire            flush,
    geet_fifo_rd_if.master fifo,
    geet_stream_if.master  strm
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [2];   // skid buffer storage
    logic                  r_head;      // oldest buffered word
    logic                  r_tail;      // next free slot
    logic [1:0]            r_count;     // words in the skid buffer
    logic                  r_inflight;  // a pop was issued last cycle
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                  w_pop;       // word leaves the buffer this edge
    logic                  w_cap;       // returning FIFO word is stored this edge
    logic [2:0]            w_credit;    // occupancy once this cycle settles
    logic                  w_rd_en;
    logic [1:0]            w_count_nxt;
    logic                  w_head_nxt;
    logic                  w_tail_nxt;
    logic [DATA_WIDTH-1:0] w_head_word; // word at the head after this edge

    assign w_pop = r_valid & strm.m_ready;

    // Buffered words plus the one still returning from the FIFO, minus the
    // one leaving now. A new pop is allowed only if that leaves a free slot
    // for its data next cycle, so the buffer can never overflow. r_valid
    // implies r_count >= 1, so the subtraction cannot underflow.
    assign w_credit = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // reset_n gates the request directly so the FIFO sees no pop while the
    // block is held in reset, even with fifo_empty low.
    assign w_rd_en = reset_n & ~fifo.fifo_empty & ~flush & (w_credit < 3'd2);

    // A word returning during a flush cycle is discarded.
    assign w_cap = r_inflight & ~flush;

    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_head_word = r_mem[r_head];

        if (flush) begin
            w_count_nxt = 2'd0;
            w_head_nxt  = 1'b0;
            w_tail_nxt  = 1'b0;
        end else begin
            case ({w_cap, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
            if (w_pop) begin
                w_head_nxt = ~r_head;
            end
            if (w_cap) begin
                w_tail_nxt = ~r_tail;
            end
        end

        // When the new head is the slot being written this edge, the value
        // comes straight from the FIFO; otherwise it is already stored.
        if (w_cap && (r_tail == w_head_nxt)) begin
            w_head_word = fifo.fifo_d_out;
        end else begin
            w_head_word = r_mem[w_head_nxt];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            // w_rd_en is forced low during flush, which also clears this.
            r_inflight <= w_rd_en;
            r_valid    <= (w_count_nxt != 2'd0);
            // m_data keeps its last value once the buffer runs dry.
            if (w_count_nxt != 2'd0) begin
                r_data <= w_head_word;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_mem[r_tail] <= fifo.fifo_d_out;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fifo.fifo_rd_en = w_rd_en;
    assign strm.m_valid    = r_valid;
    assign strm.m_data     = r_data;
    assign strm.buf_count  = r_count;

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    a_no_read_when_empty : assert property (
        @(posedge clk) disable iff (!reset_n)
        !(fifo.fifo_rd_en && fifo.fifo_empty)
    );

    a_count_in_range : assert property (
        @(posedge clk) disable iff (!reset_n)
        r_count <= 2'd2
    );

endmodule

`default_nettype wire

// File: tb/tb_geet_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_geet_fifo_stream_reader
//  Description : Self-checking bench for geet_fifo_stream_reader. A queue
//                model of a registered-output FIFO drives the read port; a
//                scoreboard of popped words checks the stream order.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_geet_fifo_stream_reader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          m_ready;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_d_out = '0;
    logic          rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    buf_count;

    geet_fifo_rd_if #(.DATA_WIDTH(DW)) fif ();
    geet_stream_if  #(.DATA_WIDTH(DW)) sif ();

    assign fif.fifo_empty = fifo_empty;
    assign fif.fifo_d_out = fifo_d_out;
    assign rd_en          = fif.fifo_rd_en;
    assign sif.m_ready    = m_ready;
    assign m_valid        = sif.m_valid;
    assign m_data         = sif.m_data;
    assign buf_count      = sif.buf_count;

    geet_fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .fifo    (fif.master),
        .strm    (sif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int n_deliv = 0;
    bit log_en = 1'b0;

    logic [DW-1:0] fq[$];    // FIFO contents
    logic [DW-1:0] wq[$];    // words written into the FIFO at the next edge
    logic [DW-1:0] rq[$];    // words popped from the FIFO, not yet delivered
    logic [DW-1:0] dlog[$];  // delivered words (random test)
    logic [DW-1:0] fm_word;
    logic [DW-1:0] sb_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Registered-output FIFO: data and empty flag change only at the edge.
    // Words popped but never delivered are forgotten on reset or flush.
    always @(posedge clk) begin
        if (!reset_n || flush) begin
            rq.delete();
        end
        if (rd_en && fq.size() > 0) begin
            fm_word = fq.pop_front();
            fifo_d_out <= fm_word;
            rq.push_back(fm_word);
        end
        while (wq.size() > 0) begin
            fq.push_back(wq.pop_front());
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor: every accepted word must be the oldest popped word.
    always @(negedge clk) begin
        if (rd_en && fifo_empty) begin
            viol++;
            $display("FAIL rd_when_empty at %0t", $time);
        end
        if (reset_n && !flush && m_valid && m_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL stream_word: got %0h expected none", m_data);
            end else begin
                sb_exp = rq.pop_front();
                if (m_data !== sb_exp) begin
                    errors++;
                    $display("FAIL stream_word: got %0h expected %0h", m_data, sb_exp);
                end
            end
            n_deliv++;
            if (log_en) dlog.push_back(m_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic          rdy;
        logic          e_valid;
        logic          e_dchk;
        logic [DW-1:0] e_data;
        logic [1:0]    e_count;
        logic          e_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdp, vc, first, found, d0, mism, pushed, cnt;
        logic [DW-1:0] seen;
        logic [DW-1:0] wlog[$];

        // Back-pressure sequence on words 0x10..0x13: ready low once the
        // first word shows, then released.
        tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h10, 2'd1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h10, 2'd2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h10, 2'd2, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h10, 2'd2, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h11, 2'd1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h12, 2'd1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h13, 2'd1, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h13, 2'd0, 1'b0};

        reset_n = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_valid", m_valid, 0);
        chk("reset_count", buf_count, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_data", m_data, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // ---------------- streaming 0x00..0x0F ----------------
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) wq.push_back(i);
        for (int k = 0; k < 20; k++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("stream_rd_en[%0d]", k), rd_en, (k < 16));
            chk($sformatf("stream_valid[%0d]", k), m_valid, (k >= 2 && k < 18));
            if (k >= 2 && k < 18) chk($sformatf("stream_data[%0d]", k), m_data, k - 2);
        end

        // ---------------- back-pressure table ----------------
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wq.push_back(32'h10 + i);
        for (int k = 0; k < 10; k++) begin
            cyc();
            m_ready = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("bp_valid[%0d]", k), m_valid, tbl[k].e_valid);
            chk($sformatf("bp_count[%0d]", k), buf_count, tbl[k].e_count);
            chk($sformatf("bp_rd_en[%0d]", k), rd_en, tbl[k].e_rd);
            if (tbl[k].e_dchk) chk($sformatf("bp_data[%0d]", k), m_data, tbl[k].e_data);
        end

        // ---------------- single last word ----------------
        cyc();
        m_ready = 1'b1;
        wq.push_back(32'hAB);
        rdp = 0; vc = 0; first = -1; seen = '0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            @(negedge clk);
            if (rd_en) rdp++;
            if (m_valid) begin
                vc++;
                if (first < 0) first = k;
                seen = m_data;
            end
        end
        chk("last_rd_pulses", rdp, 1);
        chk("last_valid_cycles", vc, 1);
        chk("last_latency", first, 2);
        chk("last_data", seen, 32'hAB);

        // ---------------- flush with inflight=1, buf_count=1 ----------------
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wq.push_back(32'h60 + i);
        repeat (3) cyc();
        chk("flush_pre_count", buf_count, 1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rd_en", rd_en, 0);
        cyc();
        flush   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", m_valid, 0);
        chk("flush_count", buf_count, 0);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            cyc();
            @(negedge clk);
            if (m_valid) begin
                found = 1;
                seen  = m_data;
            end
        end
        chk("flush_next_found", found, 1);
        chk("flush_next_word", seen, 32'h62);
        repeat (8) cyc();

        // ---------------- reset mid-stream with buf_count=2 ----------------
        cyc();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wq.push_back(32'h70 + i);
        repeat (4) cyc();
        chk("rst_pre_count", buf_count, 2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_count", buf_count, 0);
        chk("rst_rd_en", rd_en, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ready = 1'b1;
        d0 = n_deliv;
        repeat (12) cyc();
        chk("rst_words_after", n_deliv - d0, 2);
        chk("rst_fifo_drained", fq.size(), 0);

        // ---------------- random traffic, 1000 words ----------------
        dlog.delete();
        log_en = 1'b1;
        pushed = 0;
        cnt    = 0;
        while (dlog.size() < 1000 && cnt < 20000) begin
            cyc();
            m_ready = ($urandom_range(0, 1) == 1);
            if (pushed < 1000 && $urandom_range(0, 99) < 55) begin
                seen = $urandom;
                wq.push_back(seen);
                wlog.push_back(seen);
                pushed++;
            end
            cnt++;
        end
        log_en = 1'b0;
        chk("rand_count", dlog.size(), 1000);
        mism = 0;
        for (int i = 0; i < dlog.size() && i < wlog.size(); i++) begin
            if (dlog[i] !== wlog[i]) mism++;
        end
        chk("rand_order", mism, 0);
        m_ready = 1'b1;
        repeat (5) cyc();

        chk("no_read_when_empty", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
